// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares a two-input Mux between two valid/ready requesters.
// The selected word is captured into a one-deep output register that a downstream consumer drains.
module mux_rr_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic             in1_valid,
   output logic             in1_ready,
   output logic             mux_sel,
   input  logic [WIDTH-1:0] mux_out,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t             state_reg;
   state_t             state_next;
   logic               last_grant_reg;
   logic [WIDTH-1:0]   out_data_reg;
   logic               out_src_reg;
   logic               grant;
   logic               load;
   logic               any_req;
   logic               transfer;

   assign out_valid = (state_reg == FULL);
   assign out_data  = out_data_reg;
   assign out_src   = out_src_reg;

   assign load     = !out_valid || out_ready;
   assign any_req  = in0_valid || in1_valid;
   assign transfer = load && any_req;

   // Under contention the requester that did not win last time gets the slot.
   always_comb begin
      grant = 1'b0;
      if (in0_valid && in1_valid) begin
         grant = ~last_grant_reg;
      end else if (in1_valid) begin
         grant = 1'b1;
      end
   end

   assign mux_sel = grant;

   // Gated by rst_n so no requester sees a handshake while reset is held.
   assign in0_ready = rst_n && load && in0_valid && (grant == 1'b0);
   assign in1_ready = rst_n && load && in1_valid && (grant == 1'b1);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY: begin
            if (any_req) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (out_ready && !any_req) begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // Data, source and fairness pointer only move on an actual transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg   <= '0;
         out_src_reg    <= 1'b0;
         last_grant_reg <= 1'b1;
      end else if (transfer) begin
         out_data_reg   <= mux_out;
         out_src_reg    <= grant;
         last_grant_reg <= grant;
      end
   end

endmodule
